// File: rtl/img_rsz_blk_sched.sv
// img_rsz_blk_sched: raster-order block-job scheduler with bounded in-flight jobs and BlkIsExec scoreboard.
// Define IMG_RSZ_SCHED_ERR_CHK_EN to add the sticky err_flag_o done-channel checker.
module img_rsz_blk_sched #(
  parameter int BLK_X_NUM   = 4,
  parameter int BLK_Y_NUM   = 4,
  parameter int BLK_X_IDX_W = (BLK_X_NUM > 1) ? $clog2(BLK_X_NUM) : 1,
  parameter int BLK_Y_IDX_W = (BLK_Y_NUM > 1) ? $clog2(BLK_Y_NUM) : 1,
  parameter int MAX_OUTST   = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                frm_start_i,
  output logic                                frm_busy_o,
  output logic                                frm_done_o,
  output logic [BLK_X_IDX_W-1:0]              job_x_o,
  output logic [BLK_Y_IDX_W-1:0]              job_y_o,
  output logic                                job_vld_o,
  input  logic                                job_rdy_i,
  input  logic                                done_vld_i,
  input  logic [BLK_X_IDX_W-1:0]              done_x_i,
  input  logic [BLK_Y_IDX_W-1:0]              done_y_i,
  output logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0] blk_is_exec_o,
  input  logic [BLK_X_NUM-1:0]                flush_blk_x_msk_i,
  input  logic [BLK_Y_NUM-1:0]                flush_blk_y_msk_i,
  input  logic                                flush_vld_i
`ifdef IMG_RSZ_SCHED_ERR_CHK_EN
  ,
  output logic                                err_flag_o
`endif
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);
  localparam logic [BLK_X_IDX_W-1:0] LAST_X = BLK_X_IDX_W'(BLK_X_NUM - 1);
  localparam logic [BLK_Y_IDX_W-1:0] LAST_Y = BLK_Y_IDX_W'(BLK_Y_NUM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                              state_q;
  logic [OW-1:0]                       outst_q, outst_d;
  logic [BLK_X_IDX_W-1:0]              job_x_q;
  logic [BLK_Y_IDX_W-1:0]              job_y_q;
  logic                                job_vld_q, busy_q, done_q;
  logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0] exec_q, exec_d, set_v, clr_v;
  logic                                hs, dec, last_x, last_job;

  assign hs       = job_vld_q & job_rdy_i;
  assign dec      = done_vld_i & (outst_q != '0);
  assign outst_d  = outst_q + OW'(hs) - OW'(dec);
  assign last_x   = job_x_q == LAST_X;
  assign last_job = last_x & (job_y_q == LAST_Y);

  // Out-of-range done indices match no bit, so they only touch the counter.
  for (genvar y = 0; y < BLK_Y_NUM; y++) begin : g_y
    for (genvar x = 0; x < BLK_X_NUM; x++) begin : g_x
      assign set_v[y][x] = done_vld_i & (done_y_i == BLK_Y_IDX_W'(y)) & (done_x_i == BLK_X_IDX_W'(x));
      assign clr_v[y][x] = flush_vld_i & flush_blk_y_msk_i[y] & flush_blk_x_msk_i[x];
    end
  end

  assign exec_d = set_v | (exec_q & ~clr_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      outst_q   <= '0;
      exec_q    <= '0;
      job_x_q   <= '0;
      job_y_q   <= '0;
      job_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      outst_q <= outst_d;
      exec_q  <= exec_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (frm_start_i) begin
          state_q   <= ISSUE;
          busy_q    <= 1'b1;
          job_vld_q <= outst_d < MAX_O;
        end
        ISSUE: begin
          job_vld_q <= outst_d < MAX_O;
          if (hs) begin
            job_x_q <= last_x ? '0 : job_x_q + BLK_X_IDX_W'(1);
            job_y_q <= last_job ? '0 : last_x ? job_y_q + BLK_Y_IDX_W'(1) : job_y_q;
            if (last_job) begin
              state_q   <= DRAIN;
              job_vld_q <= 1'b0;
            end
          end
        end
        DRAIN: if (outst_q == '0 && exec_q == '0) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frm_busy_o    = busy_q;
  assign frm_done_o    = done_q;
  assign job_x_o       = job_x_q;
  assign job_y_o       = job_y_q;
  assign job_vld_o     = job_vld_q;
  assign blk_is_exec_o = exec_q;

`ifdef IMG_RSZ_SCHED_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (done_vld_i && (outst_q == '0 || set_v == '0 || (set_v & exec_q) != '0)) err_q <= 1'b1;
  end
  assign err_flag_o = err_q;
`endif
endmodule
